wb_stage: RTL and testbench
===========================

Name: wb_stage

Overview:
- Write-back stage of the pipelined CPU, directly upstream of the register file write port.
- Holds the MEM/WB pipeline register and aligns and sign/zero-extends load data.
- Merges results from the long-latency unit (mul/div) through a 1-entry holding buffer into the single register write port.
- Drives rf_we/rf_addr/rf_wdata; the register file forwards a same-cycle write to its read ports, so decode needs no extra bypass from this stage.

Parameters:
- XLEN, 32, datapath width.
- STARVE_LIMIT, 4, cycles the buffer may wait for the write port before requesting a pipeline stall.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- mem_valid  in  1  MEM stage holds a real instruction.
- mem_reg_write  in  1  instruction writes rd.
- mem_mem_to_reg  in  1  result is load data, not ALU result.
- mem_rd  in  5  destination register.
- mem_alu_result  in  XLEN  ALU result / load address.
- mem_load_data  in  XLEN  raw aligned memory word.
- mem_load_size  in  2  00 byte, 01 half, 10 word, 11 treated as word.
- mem_load_unsigned  in  1  zero-extend instead of sign-extend.
- wb_stall  in  1  hold the WB register.
- wb_flush  in  1  capture a bubble.
- ll_valid  in  1  long-latency result offered.
- ll_ready  out  1  buffer can accept.
- ll_rd  in  5  long-latency destination.
- ll_data  in  XLEN  long-latency result.
- rf_we  out  1  register write enable.
- rf_addr  out  5  register write address.
- rf_wdata  out  XLEN  register write data.
- ll_stall_req  out  1  asks the hazard unit to stall the pipeline.
- instret  out  CNT_W  retired-instruction count.

Behaviour:
- Reset: the WB register, buffer, starve counter, wb_done and instret all clear to 0. As a result, rf_we=0, rf_addr=0, rf_wdata=0, ll_ready=1, ll_stall_req=0 and instret=0.
- Reset mid-operation drops any buffered long-latency result silently.
- WB register update on posedge clk, in priority order:
  - wb_flush: wb_valid<=0.
  - else !wb_stall: capture all mem_* signals, plus mem_alu_result[1:0] as the byte offset.
  - else: hold.
- wb_done: set after the first cycle a valid instruction sits in WB; cleared whenever a new entry is captured or flushed.
- Commit happens only when wb_valid && !wb_done, so a stalled instruction commits exactly once.
- Load formatting (combinational from the WB register):
  - byte = data >> (8*off), extended from bit 7.
  - half = data >> (16*off[1]), extended from bit 15; off[0] is ignored.
  - word = data as-is.
  - mem_to_reg=0 selects alu_result.
- Write-port arbitration:
  - A pipeline commit with reg_write && rd!=0 takes the port: rf_we/addr/wdata come directly from the WB register, with no added latency.
  - Otherwise, if the buffer is full, it drains: rf_we=1 with the buffer's rd/data, and the buffer empties at the edge.
  - Otherwise rf_we=0; rf_addr and rf_wdata are driven 0.
- rf_we is never 1 with rf_addr=0.
- Long-latency buffer:
  - ll_ready = !buf_full | draining_this_cycle, so back-to-back transfers run at full rate.
  - A transfer happens when ll_valid && ll_ready.
  - An ll_rd==0 result is accepted and discarded (the buffer stays empty).
- Starve counter:
  - Increments each cycle the buffer is full and does not drain; resets to 0 on a drain or when the buffer is empty.
  - ll_stall_req = buf_full && (starve_cnt >= STARVE_LIMIT).
  - Upstream stalling creates a WB slot with wb_done=1, which lets the buffer drain.
- instret:
  - Increments by 1 on each edge where wb_valid && !wb_done, whether or not the instruction writes a register.
  - Wraps modulo 2^CNT_W.
- Invariant, not checked in RTL: the scoreboard prevents any younger pipeline instruction from writing an rd that is pending in the long-latency unit or buffer. Verification adds an assertion for this.

Decomposition:
- Shared package (cpu_pkg): XLEN, load size encodings (LS_BYTE, LS_HALF, LS_WORD), and REG_ZERO.
- One sub-module, load_align: combinational formatter taking data, off, size and unsigned, producing XLEN; it is reused by future MEM-stage checks.

Test Plan:
- Load byte sign: load_data=0x80FF_7F01, off=3, size=byte, signed -> rf_wdata=0xFFFF_FF80 and rf_we=1 for one cycle. Same input unsigned -> 0x0000_0080.
- Stall-once: valid ALU write rd=5 data=0x1234, then wb_stall held 3 cycles -> rf_we asserted in only the first cycle, instret increments by exactly 1.
- Port conflict: ll result rd=7 0xAAAA arrives in the same cycle as pipeline write rd=3 -> rd=3 written first, rd=7 written the next free cycle, ll_ready=0 while the buffer is full with no drain.
- Starvation: buffer full and a pipeline write every cycle -> ll_stall_req rises after 4 blocked cycles. Hazard model stalls, then the buffer drains on the following cycle and ll_stall_req falls.
- rd=0 and flush: pipeline write to rd=0 and ll result to rd=0 -> rf_we never asserts, buffer stays empty. wb_flush -> next WB content is a bubble, instret unchanged.
- Async reset mid-buffer: assert reset_n=0 while the buffer is full -> ll_ready=1, rf_we=0, instret=0 immediately, with no write after reset release.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath width, load size encodings and the
// hard-wired zero register index.
package cpu_pkg;

  localparam int XLEN = 32;

  // Load size encodings carried down the pipeline with each load.
  // 2'b11 is not a legal size; consumers treat it as a word.
  localparam logic [1:0] LS_BYTE = 2'b00;
  localparam logic [1:0] LS_HALF = 2'b01;
  localparam logic [1:0] LS_WORD = 2'b10;

  // Architectural zero register: writes to it are dropped.
  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef logic [4:0] reg_addr_t;

  // True when a write to rd actually changes architectural state.
  function automatic logic is_rf_target(input reg_addr_t rd);
    return rd != REG_ZERO;
  endfunction

endpackage

// File: rtl/load_align.sv
// Load formatter: picks the addressed byte/half out of an aligned memory
// word and sign- or zero-extends it to the datapath width.
module load_align
  import cpu_pkg::*;
#(
  parameter int XLEN = cpu_pkg::XLEN
) (
  input  logic [XLEN-1:0] i_data,
  input  logic [1:0]      i_off,
  input  logic [1:0]      i_size,
  input  logic            i_unsigned,
  output logic [XLEN-1:0] o_result
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic        w_byte_ext;
  logic        w_half_ext;

  // Byte lane is selected by the full offset; the half lane only by off[1],
  // so a misaligned half offset silently rounds down.
  assign w_byte     = i_data[{i_off, 3'b000} +: 8];
  assign w_half     = i_data[{i_off[1], 4'b0000} +: 16];
  assign w_byte_ext = ~i_unsigned & w_byte[7];
  assign w_half_ext = ~i_unsigned & w_half[15];

  // Size mux; the unused 2'b11 encoding falls through to a full word.
  always_comb begin
    o_result = i_data;
    case (i_size)
      LS_BYTE: o_result = {{(XLEN-8){w_byte_ext}}, w_byte};
      LS_HALF: o_result = {{(XLEN-16){w_half_ext}}, w_half};
      default: o_result = i_data;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: MEM/WB pipeline register, load formatting, and the
// arbiter that merges long-latency (mul/div) results into the single
// register-file write port through a one-entry holding buffer.
//
// Long-latency handshake: a result transfers on any rising edge where
// ll_valid && ll_ready. ll_ready depends only on registered state (buffer
// occupancy and whether the pipeline owns the port this cycle), never on
// ll_valid, so there is no combinational loop through the producer.
module wb_stage
  import cpu_pkg::*;
#(
  parameter int XLEN         = cpu_pkg::XLEN,
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             mem_valid,
  input  logic             mem_reg_write,
  input  logic             mem_mem_to_reg,
  input  logic [4:0]       mem_rd,
  input  logic [XLEN-1:0]  mem_alu_result,
  input  logic [XLEN-1:0]  mem_load_data,
  input  logic [1:0]       mem_load_size,
  input  logic             mem_load_unsigned,
  input  logic             wb_stall,
  input  logic             wb_flush,
  input  logic             ll_valid,
  output logic             ll_ready,
  input  logic [4:0]       ll_rd,
  input  logic [XLEN-1:0]  ll_data,
  output logic             rf_we,
  output logic [4:0]       rf_addr,
  output logic [XLEN-1:0]  rf_wdata,
  output logic             ll_stall_req,
  output logic [CNT_W-1:0] instret
);

  // Starve counter saturates at STARVE_LIMIT, so it only needs to hold that.
  localparam int              SC_W     = $clog2(STARVE_LIMIT + 2);
  localparam logic [SC_W-1:0] SC_LIMIT = SC_W'(STARVE_LIMIT);

  // MEM/WB pipeline register
  logic            r_wb_valid;
  logic            r_wb_reg_write;
  logic            r_wb_mem_to_reg;
  reg_addr_t       r_wb_rd;
  logic [XLEN-1:0] r_wb_alu;
  logic [XLEN-1:0] r_wb_load_data;
  logic [1:0]      r_wb_size;
  logic            r_wb_unsigned;
  logic [1:0]      r_wb_off;
  logic            r_wb_done;

  // Long-latency holding buffer
  logic            r_buf_full;
  reg_addr_t       r_buf_rd;
  logic [XLEN-1:0] r_buf_data;
  logic [SC_W-1:0] r_starve_cnt;

  logic [CNT_W-1:0] r_instret;

  logic [XLEN-1:0] w_load_fmt;
  logic [XLEN-1:0] w_wb_result;
  logic            w_commit;
  logic            w_pipe_wr;
  logic            w_drain;
  logic            w_ll_take;
  logic            w_ll_keep;

  load_align #(
    .XLEN(XLEN)
  ) u_load_align (
    .i_data     (r_wb_load_data),
    .i_off      (r_wb_off),
    .i_size     (r_wb_size),
    .i_unsigned (r_wb_unsigned),
    .o_result   (w_load_fmt)
  );

  assign w_wb_result = r_wb_mem_to_reg ? w_load_fmt : r_wb_alu;

  // An instruction commits once: on its first cycle in WB. wb_done blocks
  // re-commits while the stage is stalled.
  assign w_commit  = r_wb_valid & ~r_wb_done;
  assign w_pipe_wr = w_commit & r_wb_reg_write & is_rf_target(r_wb_rd);

  // The pipeline always wins the port; the buffer uses any free cycle.
  assign w_drain   = r_buf_full & ~w_pipe_wr;
  assign ll_ready  = ~r_buf_full | w_drain;
  assign w_ll_take = ll_valid & ll_ready;
  // A result for x0 completes the handshake but is not worth buffering.
  assign w_ll_keep = w_ll_take & is_rf_target(ll_rd);

  assign ll_stall_req = r_buf_full & (r_starve_cnt >= SC_LIMIT);
  assign instret      = r_instret;

  // Write-port mux: pipeline commit, else buffer drain, else idle with zeros.
  always_comb begin
    rf_we    = 1'b0;
    rf_addr  = REG_ZERO;
    rf_wdata = '0;
    if (w_pipe_wr) begin
      rf_we    = 1'b1;
      rf_addr  = r_wb_rd;
      rf_wdata = w_wb_result;
    end else if (r_buf_full) begin
      rf_we    = 1'b1;
      rf_addr  = r_buf_rd;
      rf_wdata = r_buf_data;
    end
  end

  // MEM/WB register: flush beats capture, stall holds.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wb_valid      <= 1'b0;
      r_wb_reg_write  <= 1'b0;
      r_wb_mem_to_reg <= 1'b0;
      r_wb_rd         <= REG_ZERO;
      r_wb_alu        <= '0;
      r_wb_load_data  <= '0;
      r_wb_size       <= LS_BYTE;
      r_wb_unsigned   <= 1'b0;
      r_wb_off        <= 2'b00;
    end else if (wb_flush) begin
      r_wb_valid <= 1'b0;
    end else if (!wb_stall) begin
      r_wb_valid      <= mem_valid;
      r_wb_reg_write  <= mem_reg_write;
      r_wb_mem_to_reg <= mem_mem_to_reg;
      r_wb_rd         <= mem_rd;
      r_wb_alu        <= mem_alu_result;
      r_wb_load_data  <= mem_load_data;
      r_wb_size       <= mem_load_size;
      r_wb_unsigned   <= mem_load_unsigned;
      r_wb_off        <= mem_alu_result[1:0];
    end
  end

  // wb_done marks a held instruction as already committed.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wb_done <= 1'b0;
    end else if (wb_flush || !wb_stall) begin
      r_wb_done <= 1'b0;
    end else if (r_wb_valid) begin
      r_wb_done <= 1'b1;
    end
  end

  // Holding buffer: a new keepable result may refill it in the same cycle
  // it drains, which gives back-to-back throughput.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_buf_full <= 1'b0;
      r_buf_rd   <= REG_ZERO;
      r_buf_data <= '0;
    end else if (w_ll_keep) begin
      r_buf_full <= 1'b1;
      r_buf_rd   <= ll_rd;
      r_buf_data <= ll_data;
    end else if (w_drain) begin
      r_buf_full <= 1'b0;
    end
  end

  // Starve counter: cycles the buffered result has been denied the port.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_starve_cnt <= '0;
    end else if (!r_buf_full || w_drain) begin
      r_starve_cnt <= '0;
    end else if (r_starve_cnt < SC_LIMIT) begin
      r_starve_cnt <= r_starve_cnt + 1'b1;
    end
  end

  // Retired-instruction counter, wraps naturally at 2^CNT_W.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_instret <= '0;
    end else if (w_commit) begin
      r_instret <= r_instret + 1'b1;
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: directed scenarios followed by a randomized phase,
// all checked against a transaction-level model of the write-back stage.
module tb_wb_stage;

  localparam int XLEN         = 32;
  localparam int STARVE_LIMIT = 4;
  localparam int CNT_W        = 32;

  logic             clk;
  logic             reset_n;
  logic             mem_valid;
  logic             mem_reg_write;
  logic             mem_mem_to_reg;
  logic [4:0]       mem_rd;
  logic [XLEN-1:0]  mem_alu_result;
  logic [XLEN-1:0]  mem_load_data;
  logic [1:0]       mem_load_size;
  logic             mem_load_unsigned;
  logic             wb_stall;
  logic             wb_flush;
  logic             ll_valid;
  logic             ll_ready;
  logic [4:0]       ll_rd;
  logic [XLEN-1:0]  ll_data;
  logic             rf_we;
  logic [4:0]       rf_addr;
  logic [XLEN-1:0]  rf_wdata;
  logic             ll_stall_req;
  logic [CNT_W-1:0] instret;

  wb_stage #(
    .XLEN(XLEN), .STARVE_LIMIT(STARVE_LIMIT), .CNT_W(CNT_W)
  ) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .mem_valid         (mem_valid),
    .mem_reg_write     (mem_reg_write),
    .mem_mem_to_reg    (mem_mem_to_reg),
    .mem_rd            (mem_rd),
    .mem_alu_result    (mem_alu_result),
    .mem_load_data     (mem_load_data),
    .mem_load_size     (mem_load_size),
    .mem_load_unsigned (mem_load_unsigned),
    .wb_stall          (wb_stall),
    .wb_flush          (wb_flush),
    .ll_valid          (ll_valid),
    .ll_ready          (ll_ready),
    .ll_rd             (ll_rd),
    .ll_data           (ll_data),
    .rf_we             (rf_we),
    .rf_addr           (rf_addr),
    .rf_wdata          (rf_wdata),
    .ll_stall_req      (ll_stall_req),
    .instret           (instret)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct {
    bit          valid;
    bit          rw;
    bit          m2r;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] ld;
    logic [1:0]  sz;
    bit          uns;
  } ent_t;

  ent_t        m_wb;
  bit          m_done;
  logic [36:0] exp_q[$];      // pending long-latency writes {rd, data}
  int          m_blocked;     // cycles the head of exp_q was denied the port
  logic [31:0] m_instret;

  int n_checks;
  int n_pass;

  // Value the instruction in WB would write, from the ISA load rules.
  function automatic logic [31:0] wb_value(input ent_t e);
    logic [31:0] v;
    int          off;
    if (!e.m2r) return e.alu;
    off = int'(e.alu % 4);
    case (e.sz)
      2'd0: begin
        v = (e.ld >> (8 * off)) % 256;
        if (!e.uns && v >= 128) v = v - 256;
      end
      2'd1: begin
        v = (e.ld >> (16 * (off / 2))) % 65536;
        if (!e.uns && v >= 32768) v = v - 65536;
      end
      default: v = e.ld;
    endcase
    return v;
  endfunction

  function automatic bit m_first_cycle();
    return m_wb.valid && !m_done;
  endfunction

  function automatic bit m_pipe_write();
    return m_first_cycle() && m_wb.rw && (m_wb.rd != 5'd0);
  endfunction

  function automatic bit m_stall_req();
    return (exp_q.size() > 0) && (m_blocked >= STARVE_LIMIT);
  endfunction

  task automatic model_reset();
    m_wb      = '{default: 0};
    m_done    = 0;
    exp_q.delete();
    m_blocked = 0;
    m_instret = '0;
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic check_outputs();
    bit          pw;
    logic        e_we;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    pw     = m_pipe_write();
    e_we   = 1'b0;
    e_addr = 5'd0;
    e_data = 32'd0;
    if (pw) begin
      e_we   = 1'b1;
      e_addr = m_wb.rd;
      e_data = wb_value(m_wb);
    end else if (exp_q.size() > 0) begin
      e_we   = 1'b1;
      e_addr = exp_q[0][36:32];
      e_data = exp_q[0][31:0];
    end
    chk("rf_we",        64'(rf_we),        64'(e_we));
    chk("rf_addr",      64'(rf_addr),      64'(e_addr));
    chk("rf_wdata",     64'(rf_wdata),     64'(e_data));
    chk("ll_ready",     64'(ll_ready),     64'((exp_q.size() == 0) || !pw));
    chk("ll_stall_req", 64'(ll_stall_req), 64'(m_stall_req()));
    chk("instret",      64'(instret),      64'(m_instret));
  endtask

  // One rising edge: advance the model with the inputs the DUT samples.
  task automatic tick();
    bit pw;
    bit full;
    bit drain;
    bit take;
    @(posedge clk);
    pw    = m_pipe_write();
    full  = exp_q.size() > 0;
    drain = full && !pw;
    take  = ll_valid && (!full || drain);
    assert (!(pw && full && exp_q[0][36:32] == m_wb.rd))
    else $error("FAIL scoreboard_invariant rd=%0d pending", m_wb.rd);
    if (m_first_cycle()) m_instret = m_instret + 1;
    if (drain) void'(exp_q.pop_front());
    if (take && ll_rd != 5'd0) exp_q.push_back({ll_rd, ll_data});
    m_blocked = (full && !drain) ? m_blocked + 1 : 0;
    if (wb_flush) begin
      m_wb.valid = 0;
      m_done     = 0;
    end else if (!wb_stall) begin
      m_wb.valid = mem_valid;
      m_wb.rw    = mem_reg_write;
      m_wb.m2r   = mem_mem_to_reg;
      m_wb.rd    = mem_rd;
      m_wb.alu   = mem_alu_result;
      m_wb.ld    = mem_load_data;
      m_wb.sz    = mem_load_size;
      m_wb.uns   = mem_load_unsigned;
      m_done     = 0;
    end else begin
      m_done = m_wb.valid;
    end
    #1;
  endtask

  task automatic step();
    check_outputs();
    tick();
  endtask

  // ---------------- drivers ----------------
  task automatic set_mem(input bit v, input bit rw, input bit m2r, input logic [4:0] rd,
                         input logic [31:0] alu, input logic [31:0] ld,
                         input logic [1:0] sz, input bit uns);
    mem_valid         = v;
    mem_reg_write     = rw;
    mem_mem_to_reg    = m2r;
    mem_rd            = rd;
    mem_alu_result    = alu;
    mem_load_data     = ld;
    mem_load_size     = sz;
    mem_load_unsigned = uns;
  endtask

  task automatic set_ll(input bit v, input logic [4:0] rd, input logic [31:0] data);
    ll_valid = v;
    ll_rd    = rd;
    ll_data  = data;
  endtask

  task automatic idle();
    set_mem(0, 0, 0, 5'd0, 32'd0, 32'd0, 2'd0, 0);
    set_ll(0, 5'd0, 32'd0);
    wb_stall = 1'b0;
    wb_flush = 1'b0;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [31:0] base;
    int          k;
    logic [4:0]  r_rd;

    n_checks = 0;
    n_pass   = 0;
    idle();
    model_reset();

    // Reset state
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    #1;
    chk("reset_rf_we",    64'(rf_we),        64'd0);
    chk("reset_rf_addr",  64'(rf_addr),      64'd0);
    chk("reset_rf_wdata", 64'(rf_wdata),     64'd0);
    chk("reset_ll_ready", 64'(ll_ready),     64'd1);
    chk("reset_stallreq", 64'(ll_stall_req), 64'd0);
    chk("reset_instret",  64'(instret),      64'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Load byte, signed and unsigned, offset 3
    set_mem(1, 1, 1, 5'd4, 32'h0000_0103, 32'h80FF_7F01, 2'd0, 0);
    step();
    idle();
    chk("lb_signed_we",   64'(rf_we),    64'd1);
    chk("lb_signed_data", 64'(rf_wdata), 64'hFFFF_FF80);
    step();
    chk("lb_signed_once", 64'(rf_we), 64'd0);
    set_mem(1, 1, 1, 5'd4, 32'h0000_0103, 32'h80FF_7F01, 2'd0, 1);
    step();
    idle();
    chk("lb_unsigned_data", 64'(rf_wdata), 64'h0000_0080);
    step();

    // Halfword and word formatting spot checks
    set_mem(1, 1, 1, 5'd8, 32'h0000_0013, 32'h8001_7FFF, 2'd1, 0);
    step();
    idle();
    chk("lh_upper_signed", 64'(rf_wdata), 64'hFFFF_8001);
    step();
    set_mem(1, 1, 1, 5'd8, 32'h0000_0002, 32'hDEAD_BEEF, 2'd3, 0);
    step();
    idle();
    chk("lw_size3", 64'(rf_wdata), 64'hDEAD_BEEF);
    step();

    // Stall-once: committed exactly once while held three cycles
    set_mem(1, 1, 0, 5'd5, 32'h0000_1234, 32'd0, 2'd2, 0);
    step();
    base = m_instret;
    idle();
    wb_stall = 1'b1;
    chk("stall_first_we",   64'(rf_we),    64'd1);
    chk("stall_first_addr", 64'(rf_addr),  64'd5);
    chk("stall_first_data", 64'(rf_wdata), 64'h1234);
    step();
    chk("stall_held_we", 64'(rf_we), 64'd0);
    step();
    step();
    wb_stall = 1'b0;
    chk("stall_instret", 64'(instret), 64'(base + 32'd1));

    // Port conflict: pipeline rd3 and ll rd7 together
    set_mem(1, 1, 0, 5'd3, 32'h0000_3333, 32'd0, 2'd2, 0);
    set_ll(1, 5'd7, 32'h0000_AAAA);
    step();
    idle();
    chk("conflict_pipe_addr", 64'(rf_addr),  64'd3);
    chk("conflict_ll_ready",  64'(ll_ready), 64'd0);
    step();
    chk("conflict_ll_addr", 64'(rf_addr),  64'd7);
    chk("conflict_ll_data", 64'(rf_wdata), 64'h0000_AAAA);
    step();
    chk("conflict_idle_we", 64'(rf_we), 64'd0);

    // Starvation: pipeline writes every cycle keep the buffer blocked
    set_mem(1, 1, 0, 5'd1, 32'h11, 32'd0, 2'd2, 0);
    set_ll(1, 5'd9, 32'h0000_9999);
    step();
    set_ll(0, 5'd0, 32'd0);
    k = 0;
    while (ll_stall_req !== 1'b1 && k < 20) begin
      set_mem(1, 1, 0, 5'(k % 4 + 1), 32'(k), 32'd0, 2'd2, 0);
      step();
      k++;
    end
    chk("starve_rise_cycles", 64'(k), 64'(STARVE_LIMIT));
    wb_stall = 1'b1;
    step();
    wb_stall = 1'b0;
    set_mem(0, 0, 0, 5'd0, 32'd0, 32'd0, 2'd0, 0);
    chk("starve_drain_we",   64'(rf_we),   64'd1);
    chk("starve_drain_addr", 64'(rf_addr), 64'd9);
    step();
    chk("starve_req_fall", 64'(ll_stall_req), 64'd0);
    step();

    // rd=0 from both sources, then flush
    set_mem(1, 1, 0, 5'd0, 32'h0000_5555, 32'd0, 2'd2, 0);
    set_ll(1, 5'd0, 32'h0000_BBBB);
    step();
    idle();
    chk("rd0_we",       64'(rf_we),    64'd0);
    chk("rd0_ll_ready", 64'(ll_ready), 64'd1);
    step();
    chk("rd0_buf_empty_we", 64'(rf_we), 64'd0);
    base = m_instret;
    set_mem(1, 1, 0, 5'd6, 32'h0000_6666, 32'd0, 2'd2, 0);
    wb_flush = 1'b1;
    step();
    idle();
    chk("flush_we", 64'(rf_we), 64'd0);
    step();
    chk("flush_instret", 64'(instret), 64'(base));

    // Randomized traffic; pipeline rds 0..15, long-latency rds 0 or 16..31
    for (int i = 0; i < 400; i++) begin
      set_mem(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              5'($urandom_range(0, 15)), $urandom, $urandom,
              2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      r_rd = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(16, 31));
      set_ll(1'($urandom_range(0, 1)), r_rd, $urandom);
      wb_stall = m_stall_req() || ($urandom_range(0, 7) == 0);
      wb_flush = ($urandom_range(0, 15) == 0);
      step();
    end

    // Async reset while the buffer holds a result
    idle();
    step();
    set_mem(1, 1, 0, 5'd2, 32'h0000_2222, 32'd0, 2'd2, 0);
    set_ll(1, 5'd20, 32'hDEAD_0020);
    step();
    set_mem(1, 1, 0, 5'd3, 32'h0000_3333, 32'd0, 2'd2, 0);
    set_ll(0, 5'd0, 32'd0);
    chk("pre_reset_ll_ready", 64'(ll_ready), 64'd0);
    #1 reset_n = 1'b0;
    #1;
    chk("async_rst_ll_ready", 64'(ll_ready),     64'd1);
    chk("async_rst_rf_we",    64'(rf_we),        64'd0);
    chk("async_rst_instret",  64'(instret),      64'd0);
    chk("async_rst_stallreq", 64'(ll_stall_req), 64'd0);
    model_reset();
    idle();
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("post_reset_no_write", 64'(rf_we), 64'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
